pcpi_mac: RTL

PCPI_MAC -- requirements
Module: pcpi_mac

---
 rtl/pcpi_mac.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pcpi_mac.sv
// pcpi_mac: PCPI coprocessor holding a 32-bit multiply-accumulate register.
// MAC runs as an iterative shift-add multiplier retiring BITS_PER_CYCLE
// multiplier bits per cycle. CLR, RDACC and SETACC complete in a single step.
// The result is presented for one DONE cycle with pcpi_ready and pcpi_wr high.
module pcpi_mac #(
  parameter int unsigned BITS_PER_CYCLE = 4,
  parameter logic [6:0]  OPCODE         = 7'b0001011,
  parameter logic [6:0]  FUNCT7         = 7'b0000010
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int unsigned NumSteps = 32 / BITS_PER_CYCLE;
  localparam logic [5:0]  LastStep = 6'(NumSteps - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] F3_MAC   = 3'b000;
  localparam logic [2:0] F3_CLR   = 3'b001;
  localparam logic [2:0] F3_RDACC = 3'b010;
  localparam logic [2:0] F3_SET   = 3'b011;

  logic [1:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] partial_q, partial_d;
  logic [5:0]  count_q, count_d;
  // Set for the IDLE cycle right after DONE so a still-held valid is ignored.
  logic        skip_q, skip_d;

  logic        insn_hit;
  logic [2:0]  funct3;
  logic        is_mac, is_clr, is_rdacc, is_set;
  logic [31:0] step;
  logic [31:0] mac_sum;

  // Register-number fields of the instruction play no role in this unit.
  logic unused_insn_fields;
  assign unused_insn_fields = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign funct3   = pcpi_insn[14:12];
  assign insn_hit = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7);
  assign is_mac   = insn_hit && (funct3 == F3_MAC);
  assign is_clr   = insn_hit && (funct3 == F3_CLR);
  assign is_rdacc = insn_hit && (funct3 == F3_RDACC);
  assign is_set   = insn_hit && (funct3 == F3_SET);

  // Partial product for this cycle: multiplicand times the low multiplier bits.
  always_comb begin
    step = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) begin
        step = step + (mcand_q << i);
      end
    end
  end

  // Final accumulate value when the last step retires; wraps mod 2^32.
  assign mac_sum = acc_q + partial_q + step;

  // Next-state logic for the FSM, accumulator and multiplier datapath.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    count_d   = count_q;
    skip_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!skip_q) begin
          if (is_mac) begin
            mcand_d   = pcpi_rs1;
            mplier_d  = pcpi_rs2;
            partial_d = '0;
            count_d   = '0;
            state_d   = CALC;
          end else if (is_clr) begin
            result_d = acc_q;
            acc_d    = '0;
            state_d  = DONE;
          end else if (is_rdacc) begin
            result_d = acc_q;
            state_d  = DONE;
          end else if (is_set) begin
            result_d = acc_q;
            acc_d    = pcpi_rs1;
            state_d  = DONE;
          end
        end
      end

      CALC: begin
        if (!pcpi_valid) begin
          // CPU withdrew the request: drop the op, accumulator untouched.
          state_d = IDLE;
        end else begin
          partial_d = partial_q + step;
          mcand_d   = mcand_q << BITS_PER_CYCLE;
          mplier_d  = mplier_q >> BITS_PER_CYCLE;
          count_d   = count_q + 6'd1;
          if (count_q == LastStep) begin
            acc_d    = mac_sum;
            result_d = mac_sum;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        skip_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      result_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      count_q   <= '0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      count_q   <= count_d;
      skip_q    <= skip_d;
    end
  end

  // Outputs decode from state only, so reset clears them without a clock.
  always_comb begin
    pcpi_ready = (state_q == DONE);
    pcpi_wr    = (state_q == DONE);
    pcpi_wait  = (state_q == CALC);
    pcpi_rd    = (state_q == DONE) ? result_q : 32'h0;
  end

endmodule
